// File: rtl/branch_history_predictor_if.sv
// Fetch-lookup and resolve-training signals of the two-level branch predictor.
// The pipeline side drives stall, fetch and update fields. The predictor
// returns the local and global 2-bit counters.
interface branch_history_predictor_if;
  logic        stall;
  logic [31:0] fetch_pc;
  logic [1:0]  local_state;
  logic [1:0]  global_state;
  logic        update_valid;
  logic [6:0]  update_opcode;
  logic [31:0] update_pc;
  logic        update_taken;

  modport master (
    output stall, fetch_pc, update_valid, update_opcode, update_pc, update_taken,
    input  local_state, global_state
  );

  modport slave (
    input  stall, fetch_pc, update_valid, update_opcode, update_pc, update_taken,
    output local_state, global_state
  );
endinterface

// File: rtl/branch_history_predictor.sv
// Two-level branch predictor. The local side is a per-PC history table that
// indexes a local pattern table. The global side is a gshare history register
// XORed with PC bits that indexes a global pattern table. Lookups are
// registered with one cycle of latency. Training happens on resolved,
// unstalled conditional branches. Every lookup and training index uses the
// state as it was before the edge.
module branch_history_predictor #(
  parameter int LHT_IDX_BITS = 4,
  parameter int LHIST_BITS   = 4,
  parameter int GHIST_BITS   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  branch_history_predictor_if.slave   bus
);

  localparam int          LHT_N         = 1 << LHT_IDX_BITS;
  localparam int          LPHT_N        = 1 << LHIST_BITS;
  localparam int          GPHT_N        = 1 << GHIST_BITS;
  localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
  localparam logic [1:0]  WEAK_NT       = 2'b01;

  // Saturating 2-bit counter step: taken counts up, not-taken counts down.
  function automatic logic [1:0] train_ctr(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  logic [LHIST_BITS-1:0] lht  [LHT_N];
  logic [1:0]            lpht [LPHT_N];
  logic [1:0]            gpht [GPHT_N];
  logic [GHIST_BITS-1:0] ghr;

  logic [LHT_IDX_BITS-1:0] f_lidx;
  logic [LHT_IDX_BITS-1:0] u_lidx;
  logic [GHIST_BITS-1:0]   f_gidx;
  logic [GHIST_BITS-1:0]   u_gidx;
  logic [LHIST_BITS-1:0]   u_hist;
  logic                    train;

  assign f_lidx = bus.fetch_pc[LHT_IDX_BITS+1:2];
  assign u_lidx = bus.update_pc[LHT_IDX_BITS+1:2];
  assign f_gidx = ghr ^ bus.fetch_pc[GHIST_BITS+1:2];
  assign u_gidx = ghr ^ bus.update_pc[GHIST_BITS+1:2];
  assign u_hist = lht[u_lidx];
  assign train  = bus.update_valid && (bus.update_opcode == BRANCH_OPCODE) && !bus.stall;

  // Upper PC bits and byte-offset bits are not part of any index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc, bus.update_pc};

  // Registered lookup of both pattern tables for the accepted fetch PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.local_state  <= WEAK_NT;
      bus.global_state <= WEAK_NT;
    end else if (!bus.stall) begin
      // NOTE: non-blocking assignments make every read in this edge see pre-edge
      // table contents, which gives the read-before-write collision behaviour.
      bus.local_state  <= lpht[lht[f_lidx]];
      bus.global_state <= gpht[f_gidx];
    end
  end

  // Local history table: shift the resolved direction into the branch's history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tables are plain flops rather than RAM macros so that the
      // asynchronous reset can clear them. A RAM cannot be reset this way.
      for (int i = 0; i < LHT_N; i++) lht[i] <= '0;
    end else if (train) begin
      lht[u_lidx] <= {u_hist[LHIST_BITS-2:0], bus.update_taken};
    end
  end

  // Local pattern table: train the counter selected by the pre-edge local history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LPHT_N; i++) lpht[i] <= WEAK_NT;
    end else if (train) begin
      lpht[u_hist] <= train_ctr(lpht[u_hist], bus.update_taken);
    end
  end

  // Global pattern table: train the gshare-indexed counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GPHT_N; i++) gpht[i] <= WEAK_NT;
    end else if (train) begin
      gpht[u_gidx] <= train_ctr(gpht[u_gidx], bus.update_taken);
    end
  end

  // Global history register: shift in every trained branch outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (train) begin
      ghr <= {ghr[GHIST_BITS-2:0], bus.update_taken};
    end
  end

endmodule
